host_bus_master: RTL and testbench

- Initiator for the FPGA host register bus: issues single read/write cycles on nCS/nOE/nWE/ADD/data toward the host register slave.
- Used as the on-FPGA sequencer and as the bench driver for the host register slave, replacing the external CPU.
- Local request/response handshake on one side; strobe-timed bus with configurable setup/strobe/hold on the other.

---
 rtl/host_bus_master.sv | 212 +++++++++++++++++++++
 tb/tb_host_bus_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_master.sv
// Host register bus initiator: single read/write cycles with SETUP/STROBE/HOLD/TURN phase timing.
// Optional macro HOST_WRITE_VERIFY_EN: every write is followed by an automatic read-back of the same address.
module host_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [20:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        HOST_nCS,
    output logic        HOST_nOE,
    output logic        HOST_nWE,
    output logic [20:0] HOST_ADD,
    output logic [15:0] HDI,
    input  logic [15:0] HDO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } state_t;

    localparam logic [3:0] C_SETUP  = 4'(SETUP_CYC);
    localparam logic [3:0] C_STROBE = 4'(STROBE_CYC);
    localparam logic [3:0] C_HOLD   = 4'(HOLD_CYC);
    localparam logic [3:0] C_TURN   = 4'(TURN_CYC);

`ifdef HOST_WRITE_VERIFY_EN
    localparam bit C_VERIFY = 1'b1;
`else
    localparam bit C_VERIFY = 1'b0;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_wr;
    logic        w_wr_nxt;
    logic        r_verify;
    logic        w_verify_nxt;
    logic        w_accept;
    logic        w_last;
    logic        w_vfy_go;
    logic        w_capture;

    logic        r_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rdata;
    logic        r_ncs;
    logic        r_noe;
    logic        r_nwe;
    logic [20:0] r_add;
    logic [15:0] r_hdi;

`ifdef HOST_WRITE_VERIFY_EN
    logic [15:0] r_wdata;
    logic        r_err;
`endif

    always_comb begin
        w_accept     = req_valid && (r_state == ST_IDLE);
        w_last       = (r_cnt == 4'd1);
        w_vfy_go     = C_VERIFY && r_wr && !r_verify;
        w_capture    = (r_state == ST_STROBE) && w_last && !r_wr;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_nxt     = r_wr;
        w_verify_nxt = r_verify;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_SETUP;
                    w_cnt_nxt    = C_SETUP;
                    w_wr_nxt     = req_wr;
                    w_verify_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                if (w_last) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = C_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_STROBE: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!w_last) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (C_TURN != 4'd0) begin
                    w_state_nxt = ST_TURN;
                    w_cnt_nxt   = C_TURN;
                end else if (w_vfy_go) begin
                    w_state_nxt  = ST_SETUP;
                    w_cnt_nxt    = C_SETUP;
                    w_wr_nxt     = 1'b0;
                    w_verify_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_TURN: begin
                if (!w_last) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (w_vfy_go) begin
                    w_state_nxt  = ST_SETUP;
                    w_cnt_nxt    = C_SETUP;
                    w_wr_nxt     = 1'b0;
                    w_verify_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Bus outputs are computed from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_verify    <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_ncs       <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_add       <= '0;
            r_hdi       <= '0;
`ifdef HOST_WRITE_VERIFY_EN
            r_wdata     <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wr        <= w_wr_nxt;
            r_verify    <= w_verify_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_ncs       <= !(w_state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD});
            r_noe       <= !((w_state_nxt == ST_STROBE) && !w_wr_nxt);
            r_nwe       <= !((w_state_nxt == ST_STROBE) && w_wr_nxt);
            // The write half of a verified write completes silently; only the read-back responds.
            r_rsp_valid <= (w_state_nxt == ST_HOLD) && (w_cnt_nxt == 4'd1)
                           && !(C_VERIFY && w_wr_nxt && !w_verify_nxt);
            if (w_accept) begin
                r_add <= req_addr;
                r_hdi <= req_wr ? req_wdata : '0;
            end else if ((w_state_nxt != r_state)
                         && (w_state_nxt inside {ST_TURN, ST_IDLE, ST_SETUP})) begin
                r_hdi <= '0;
            end
            if (w_capture) begin
                r_rdata <= HDO;
            end
`ifdef HOST_WRITE_VERIFY_EN
            if (w_accept) begin
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_err <= r_verify && (HDO != r_wdata);
            end
`endif
        end
    end

    assign req_ready = r_ready;
    assign busy      = !r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign HOST_nCS  = r_ncs;
    assign HOST_nOE  = r_noe;
    assign HOST_nWE  = r_nwe;
    assign HOST_ADD  = r_add;
    assign HDI       = r_hdi;

`ifdef HOST_WRITE_VERIFY_EN
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_host_bus_master.sv
// Scoreboard bench for host_bus_master: default-timing instance against a small register slave,
// plus a second instance with SETUP=3/STROBE=2/HOLD=2/TURN=0 and a constant read-data source.
module tb_host_bus_master;

`ifdef HOST_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [20:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        HOST_nCS;
    logic        HOST_nOE;
    logic        HOST_nWE;
    logic [20:0] HOST_ADD;
    logic [15:0] HDI;
    logic [15:0] HDO = '0;

    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic        req1_wr = 1'b0;
    logic [20:0] req1_addr = '0;
    logic [15:0] req1_wdata = '0;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic        rsp1_err;
    logic        busy1;
    logic        nCS1;
    logic        nOE1;
    logic        nWE1;
    logic [20:0] ADD1;
    logic [15:0] HDI1;
    logic [15:0] HDO1 = 16'h5A5A;

    logic [15:0] smem [64] = '{default: '0};
    logic [15:0] mmem [64] = '{default: '0};
    logic [15:0] m_hdo = '0;
    logic [15:0] m_rsp = '0;
    logic [15:0] exp_hdi = '0;
    logic [20:0] exp_addr = '0;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    int   last_rsp = 0;
    int   cs_run = 0;
    int   oe_run = 0;
    int   we_run = 0;

    host_bus_master dut (
        .clk(clk), .nRESET(nRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HOST_nCS(HOST_nCS), .HOST_nOE(HOST_nOE), .HOST_nWE(HOST_nWE),
        .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO)
    );

    host_bus_master #(
        .SETUP_CYC(3), .STROBE_CYC(2), .HOLD_CYC(2), .TURN_CYC(0)
    ) dut1 (
        .clk(clk), .nRESET(nRESET),
        .req_valid(req1_valid), .req_ready(req1_ready), .req_wr(req1_wr),
        .req_addr(req1_addr), .req_wdata(req1_wdata),
        .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata), .rsp_err(rsp1_err), .busy(busy1),
        .HOST_nCS(nCS1), .HOST_nOE(nOE1), .HOST_nWE(nWE1),
        .HOST_ADD(ADD1), .HDI(HDI1), .HDO(HDO1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: 64 RW words at 0x00-0x3F, ID word 0x002A at 0x92, HDO holds on unmapped reads.
    always @(posedge clk) begin
        if (!HOST_nCS && !HOST_nWE && (HOST_ADD < 21'd64)) smem[HOST_ADD[5:0]] <= HDI;
        if (!HOST_nCS && !HOST_nOE) begin
            if (HOST_ADD == 21'h92) HDO <= 16'h002A;
            else if (HOST_ADD < 21'd64) HDO <= smem[HOST_ADD[5:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [20:0] a);
        if (a == 21'h92) m_hdo = 16'h002A;
        else if (a < 21'd64) m_hdo = mmem[a[5:0]];
        return m_hdo;
    endfunction

    // Monitor: accept timestamps, response scoreboard, strobe shape and bus contents.
    always @(negedge clk) begin
        if (!nRESET) begin
            cs_run = 0;
            oe_run = 0;
            we_run = 0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                last_acc = cyc + 1;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_latency", cyc + 1 - a, e.lat);
                    last_rsp = cyc + 1;
                end
            end
            if (!HOST_nCS) begin
                cs_run++;
                check("strobe_excl", HOST_nOE | HOST_nWE, 1);
                check("bus_addr", HOST_ADD, exp_addr);
            end else begin
                check("hdi_idle", HDI, 0);
                if (cs_run != 0) check("ncs_len", cs_run, 5);
                cs_run = 0;
            end
            if (!HOST_nWE) begin
                if (we_run == 0) check("nwe_start", cyc + 1 - last_acc, 2);
                we_run++;
                check("hdi_write", HDI, exp_hdi);
            end else begin
                if (we_run != 0) check("nwe_len", we_run, 3);
                we_run = 0;
            end
            if (!HOST_nOE) begin
                oe_run++;
                check("hdi_read", HDI, 0);
            end else begin
                if (oe_run != 0) check("noe_len", oe_run, 3);
                oe_run = 0;
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic do_req(input logic wr, input logic [20:0] a, input logic [15:0] d,
                          input bit keep, input bit expect_rsp);
        exp_t e;
        bit   ok;
        if (expect_rsp) begin
            if (wr && (a < 21'd64)) mmem[a[5:0]] = d;
            if (!wr || VFY) e.rdata = m_read(a);
            else e.rdata = m_rsp;
            m_rsp = e.rdata;
            e.err = VFY && wr && (e.rdata != d);
            e.lat = (VFY && wr) ? 11 : 5;
            exp_q.push_back(e);
        end
        exp_addr = a;
        if (wr) exp_hdi = d;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", ok, 1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", ok, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int n;
        int noe;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ncs", HOST_nCS, 1);
        check("rst_noe", HOST_nOE, 1);
        check("rst_nwe", HOST_nWE, 1);
        check("rst_add", HOST_ADD, 0);
        check("rst_hdi", HDI, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        #2 nRESET = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b1, 21'h00010, 16'h00A5, 1'b0, 1'b1);
        wait_done();
        check("slave_reg10", smem[16], 16'h00A5);

        do_req(1'b0, 21'h00092, 16'h0000, 1'b0, 1'b1);
        wait_done();

        do_req(1'b1, 21'h00020, 16'h0001, 1'b1, 1'b1);
        do_req(1'b0, 21'h00020, 16'h0000, 1'b0, 1'b1);
        check("b2b_gap", last_acc - last_rsp, 2);
        wait_done();

        req1_wr = 1'b0;
        req1_addr = 21'h00005;
        req1_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("d1_accept_seen", ok, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        check("d1_busy", busy1, 1);
        n = 0;
        noe = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (!nOE1) noe++;
            check("d1_nwe_high", nWE1, 1);
            check("d1_hdi_zero", HDI1, 0);
            if (!nCS1) check("d1_addr", ADD1, 21'h00005);
            if (rsp1_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("d1_rsp_seen", ok, 1);
        check("d1_latency", n, 7);
        check("d1_noe_len", noe, 2);
        check("d1_rdata", rsp1_rdata, 16'h5A5A);
        check("d1_err", rsp1_err, 0);
        @(negedge clk);
        check("d1_ready_after", req1_ready, 1);
        @(posedge clk);
        #1;

        do_req(1'b1, 21'h00030, 16'hBEEF, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!HOST_nWE) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_strobe_seen", ok, 1);
        #2 nRESET = 1'b0;
        #1;
        check("abort_nwe", HOST_nWE, 1);
        check("abort_noe", HOST_nOE, 1);
        check("abort_ncs", HOST_nCS, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_ready", req_ready, 1);
        check("abort_hdi", HDI, 0);
        exp_q.delete();
        acc_q.delete();
        m_rsp = '0;
        repeat (2) @(negedge clk);
        #2 nRESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_ready", req_ready, 1);
            check("post_reset_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1;

        do_req(1'b0, 21'h00010, 16'h0000, 1'b0, 1'b1);
        wait_done();

`ifdef HOST_WRITE_VERIFY_EN
        do_req(1'b1, 21'h00100, 16'h1234, 1'b0, 1'b1);
        wait_done();
        do_req(1'b1, 21'h00002, 16'h0003, 1'b0, 1'b1);
        wait_done();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
